// File: rtl/magnetron_sched.sv
// Magnetron/turntable/fan/lamp scheduler beside the cooking-control FSM.
// Power level becomes an on/off duty over a tick window; door interlock and fan overrun.
module magnetron_sched #(
    parameter int TICK_DIV    = 100,
    parameter int WINDOW      = 10,
    parameter int FAN_OVERRUN = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic       done_pulse,
    input  logic       porta,
    input  logic [2:0] power_lvl,
    output logic       magnetron,
    output logic       turntable,
    output logic       fan,
    output logic       lamp,
    output logic       busy,
    output logic       door_abort
);

    localparam int PW = $clog2(TICK_DIV + 1);
    localparam int SW = $clog2(WINDOW + 1);
    localparam int OW = (SW > 4) ? SW : 4;
    localparam int VW = $clog2(FAN_OVERRUN + 1);

    typedef enum logic [1:0] {
        IDLE,
        HEAT,
        HOLD,
        COOL
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] pcnt, pcnt_n, pcnt_adv;
    logic [OW-1:0] slot, slot_n;
    logic [OW-1:0] on_ticks, on_n, on_calc;
    logic [VW-1:0] ovr, ovr_n;
    logic [2:0]    lvl_c;
    logic          tick;
    logic          abort_n;
    logic          go_heat, go_cool, go_idle;

    always_comb begin
        lvl_c   = (power_lvl > 3'd4) ? 3'd4 : power_lvl;
        on_calc = OW'({1'b0, lvl_c, 1'b0}) + OW'(2);
        tick    = (pcnt == PW'(TICK_DIV - 1));
        pcnt_adv = tick ? '0 : pcnt + PW'(1);
    end

    always_comb begin
        state_n = state;
        pcnt_n  = pcnt;
        slot_n  = slot;
        on_n    = on_ticks;
        ovr_n   = ovr;
        abort_n = 1'b0;
        go_heat = 1'b0;
        go_cool = 1'b0;
        go_idle = 1'b0;

        unique case (state)
            IDLE: begin
                pcnt_n = '0;
                slot_n = '0;
                ovr_n  = '0;
                go_heat = run && !porta;
            end
            HEAT: begin
                if (porta) begin
                    state_n = HOLD;
                    abort_n = 1'b1;
                end else if (done_pulse || !run) begin
                    go_cool = 1'b1;
                end else begin
                    pcnt_n = pcnt_adv;
                    if (tick) begin
                        if (slot == OW'(WINDOW - 1)) begin
                            slot_n = '0;
                            on_n   = on_calc;
                        end else begin
                            slot_n = slot + OW'(1);
                        end
                    end
                end
            end
            HOLD: begin
                if (!run || done_pulse) go_cool = 1'b1;
                else if (!porta)        go_heat = 1'b1;
            end
            COOL: begin
                if (run && !porta && !done_pulse) begin
                    go_heat = 1'b1;
                end else begin
                    pcnt_n = pcnt_adv;
                    // Saturating countdown: a counter at 1 (or 0) ends the overrun.
                    if (tick) begin
                        if (ovr <= VW'(1)) go_idle = 1'b1;
                        else               ovr_n = ovr - VW'(1);
                    end
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (go_heat) begin
            state_n = HEAT;
            pcnt_n  = '0;
            slot_n  = '0;
            on_n    = on_calc;
            ovr_n   = '0;
        end
        if (go_cool) begin
            state_n = COOL;
            pcnt_n  = '0;
            slot_n  = '0;
            ovr_n   = VW'(FAN_OVERRUN);
        end
        if (go_idle) begin
            state_n = IDLE;
            pcnt_n  = '0;
            slot_n  = '0;
            ovr_n   = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pcnt     <= '0;
            slot     <= '0;
            on_ticks <= '0;
            ovr      <= '0;
        end else begin
            state    <= state_n;
            pcnt     <= pcnt_n;
            slot     <= slot_n;
            on_ticks <= on_n;
            ovr      <= ovr_n;
        end
    end

    // Outputs are decoded from the next state so they land one cycle after the input.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            magnetron  <= 1'b0;
            turntable  <= 1'b0;
            fan        <= 1'b0;
            lamp       <= 1'b0;
            busy       <= 1'b0;
            door_abort <= 1'b0;
        end else begin
            magnetron  <= (state_n == HEAT) && (slot_n < on_n);
            turntable  <= (state_n == HEAT);
            fan        <= (state_n != IDLE);
            lamp       <= (state_n == HEAT || state_n == HOLD) ? 1'b1 : porta;
            busy       <= (state_n != IDLE);
            door_abort <= abort_n;
        end
    end

endmodule

// File: doc/magnetron_sched.md
Name: magnetron_sched

Overview:
- Actuator scheduler that sits beside the microwave cooking-control FSM and drives the magnetron, turntable, fan and lamp.
- Converts the selected power level into a magnetron on/off duty cycle over a fixed tick window.
- Enforces the door interlock and runs a fan overrun period after cooking ends.
- Takes run/done from the timer controller; its outputs feed the power LEDs and the physical drivers.

Parameters:
TICK_DIV, 100, clock cycles per scheduler tick
WINDOW, 10, ticks per duty window
FAN_OVERRUN, 30, ticks the fan stays on after cooking stops

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
run  in  1  level; 1 while the timer FSM is counting down
done_pulse  in  1  one-cycle pulse when the countdown reaches 0:00
porta  in  1  door open = 1
power_lvl  in  3  power level 0..4; values 5..7 are treated as 4
magnetron  out  1  magnetron enable
turntable  out  1  turntable motor enable
fan  out  1  cooling fan enable
lamp  out  1  cavity lamp
busy  out  1  1 in any state except IDLE
door_abort  out  1  one-cycle pulse when the door opens during HEAT

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all counters 0; magnetron, turntable, fan, busy and door_abort =0; lamp=0. Applies from any state, including mid-heat.
- All outputs are registered: one-cycle latency from input change to output change.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick = 1 for one cycle when count = TICK_DIV-1.
  - Held at 0 in IDLE; cleared on every entry to HEAT or COOL.
- on_ticks = 2*(min(power_lvl,4)+1), i.e. 2/4/6/8/10 out of WINDOW (for WINDOW=10).
  - Latched on HEAT entry and whenever slot wraps to 0.
  - A power_lvl change mid-window takes effect at the next window start.
- slot counter: 0..WINDOW-1, increments on tick, wraps to 0.
- States:
  - IDLE: lamp=porta; all other outputs 0. run=1 & porta=0 -> HEAT with slot=0.
  - HEAT: magnetron = (slot < on_ticks); turntable=1, fan=1, lamp=1.
    - porta=1 -> HOLD, and door_abort pulses.
    - Otherwise done_pulse=1 or run=0 -> COOL.
  - HOLD: magnetron=0, turntable=0, fan=1, lamp=1.
    - run=0 or done_pulse=1 -> COOL.
    - porta=0 & run=1 -> HEAT with slot=0 and prescaler=0 (a fresh window).
  - COOL: magnetron=0, turntable=0, fan=1, lamp=porta.
    - Overrun counter loads FAN_OVERRUN on entry and decrements on tick; reaching 0 -> IDLE.
    - run=1 & porta=0 & done_pulse=0 -> HEAT; the overrun counter is discarded.
- Priority on simultaneous events: porta > done_pulse > run.
  - porta with done_pulse in the same cycle during HEAT -> HOLD (door_abort=1); the next cycle sees run=0 -> COOL.
- The magnetron is never 1 while porta=1, except for the single registered-latency cycle after porta rises.
- power_lvl=4 gives magnetron constantly 1 through window wraps, with no gap cycle at wrap.
- The overrun counter and slot never underflow or overflow; they saturate or wrap exactly as defined above.

Test Plan:
- TICK_DIV=4, WINDOW=10, power_lvl=1, run rises with porta=0 -> magnetron high 16 cycles, then low 24, repeating with period 40; turntable and fan steady 1; magnetron first rises 1 cycle after run.
- power_lvl=4 for 3 windows -> magnetron continuously 1. Then set power_lvl=0 mid-window -> the current window completes fully on; the next window gives 8 cycles on, 32 off.
- Door opens while magnetron=1 -> magnetron, turntable =0 next cycle; door_abort single pulse; fan=1. Door closes with run=1 -> magnetron 1 one cycle later, new window from slot 0.
- done_pulse during HEAT (FAN_OVERRUN=3, TICK_DIV=4) -> magnetron=0 next cycle; fan stays 1 for 12 cycles, then IDLE with busy=0.
- porta and done_pulse asserted in the same cycle -> HOLD with door_abort=1, then COOL; magnetron never re-asserts.
- reset driven low mid-HEAT between clock edges -> all outputs 0 immediately; after release, state IDLE until run rises.
